// File: rtl/rggen_bus_if.sv
// rggen_bus_if: generic register-bus request/response between an upstream register
// slot (master) and a bus bridge (slave).
interface rggen_bus_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
);
  logic                     valid;
  logic [ADDRESS_WIDTH-1:0] address;
  logic                     write;
  logic [BUS_WIDTH-1:0]     write_data;
  logic [BUS_WIDTH/8-1:0]   strobe;
  logic                     ready;
  logic [1:0]               status;
  logic [BUS_WIDTH-1:0]     read_data;
  modport master (
    output valid, address, write, write_data, strobe,
    input  ready, status, read_data
  );
  modport slave (
    input  valid, address, write, write_data, strobe,
    output ready, status, read_data
  );
endinterface

// File: rtl/rggen_apb_bridge.sv
// rggen_apb_bridge: runs one APB4 master transfer per rggen_bus_if request and returns a one-cycle ready.
// Define RGGEN_APB_BRIDGE_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles with SLAVE_ERROR.
module rggen_apb_bridge #(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 256
)(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  rggen_bus_if.slave               bus_if,
  output logic                     o_psel,
  output logic                     o_penable,
  output logic                     o_pwrite,
  output logic [ADDRESS_WIDTH-1:0] o_paddr,
  output logic [2:0]               o_pprot,
  output logic [BUS_WIDTH-1:0]     o_pwdata,
  output logic [BUS_WIDTH/8-1:0]   o_pstrb,
  input  logic                     i_pready,
  input  logic [BUS_WIDTH-1:0]     i_prdata,
  input  logic                     i_pslverr
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESPOND} state_e;
  state_e state, state_next;
  logic   timeout;
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 1..65535");
  end
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] count;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                       count <= '0;
    else if (state == SETUP)            count <= '0;
    else if (state == ACCESS && !i_pready) count <= count + 1'b1;
  end
  // Fires on the last permitted ACCESS cycle; a late pready in that cycle still wins.
  assign timeout = state == ACCESS && !i_pready && count == CW'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end
  always_comb begin
    state_next = state == IDLE   ? (bus_if.valid ? SETUP : IDLE) :
                 state == SETUP  ? ACCESS :
                 state == ACCESS ? ((i_pready || timeout) ? RESPOND : ACCESS) : IDLE;
  end
  always_comb begin
    o_psel       = state == SETUP || state == ACCESS;
    o_penable    = state == ACCESS;
    o_pprot      = 3'b000;
    bus_if.ready = state == RESPOND;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pwrite         <= 1'b0;
      o_paddr          <= '0;
      o_pwdata         <= '0;
      o_pstrb          <= '0;
      bus_if.status    <= 2'b00;
      bus_if.read_data <= '0;
    end else begin
      if (state == IDLE && bus_if.valid) begin
        o_pwrite <= bus_if.write;
        o_paddr  <= bus_if.address;
        o_pwdata <= bus_if.write_data;
        o_pstrb  <= bus_if.write ? bus_if.strobe : '0;
      end
      if (state == ACCESS && (i_pready || timeout)) begin
        bus_if.status    <= i_pready ? {i_pslverr, 1'b0} : 2'b10;
        bus_if.read_data <= (i_pready && !o_pwrite) ? i_prdata : '0;
      end
    end
  end
endmodule

// File: doc/rggen_apb_bridge.md
# rggen_apb_bridge

Converts the generic `rggen_bus_if` request emitted by an external-register slot into an AMBA APB4 master transfer and returns the APB response on the same interface. It sits directly downstream of the external-register stage inside the register block: that stage holds `bus_if.valid` and the request fields stable until it sees `bus_if.ready`. The bridge runs exactly one APB transfer per request and then returns one `ready` pulse carrying status and read data.

## Interface
- `ADDRESS_WIDTH`, default 8: width of `bus_if.address` and `o_paddr`.
- `BUS_WIDTH`, default 32: data width; strobe width is `BUS_WIDTH/8`.
- `TIMEOUT_CYCLES`, default 256: maximum ACCESS cycles, range 1..65535. Used only with the timeout feature.
- `i_clk`  input  1  clock.
- `i_rst_n`  input  1  reset; asynchronous, active-low.
- `bus_if`  `rggen_bus_if.slave`  -  request: `valid`, `address`, `write`, `write_data`, `strobe`; response: `ready`, `status[1:0]`, `read_data`.
- `o_psel`  output  1  APB select.
- `o_penable`  output  1  APB enable.
- `o_pwrite`  output  1  APB direction.
- `o_paddr`  output  `ADDRESS_WIDTH`  APB address.
- `o_pprot`  output  3  constant `3'b000`.
- `o_pwdata`  output  `BUS_WIDTH`  write data.
- `o_pstrb`  output  `BUS_WIDTH/8`  write strobes; forced to 0 on reads.
- `i_pready`  input  1  APB ready.
- `i_prdata`  input  `BUS_WIDTH`  APB read data.
- `i_pslverr`  input  1  APB error.

## Operation
- **FSM states:** IDLE, SETUP, ACCESS, RESPOND.
- **IDLE:**
  - If `bus_if.valid` is high: capture `address`, `write`, `write_data` and `strobe` into the APB output registers, then go to SETUP.
  - `o_pstrb` takes `strobe` on writes and 0 on reads.
- **SETUP:** `o_psel=1`, `o_penable=0`. Always goes to ACCESS.
- **ACCESS:**
  - `o_psel=1`, `o_penable=1`.
  - If `i_pready` is high: capture the response and go to RESPOND.
    - Status is `2'b10` (SLAVE_ERROR) if `i_pslverr`, else `2'b00` (OKAY).
    - Read data is `i_prdata` on reads and 0 on writes.
  - Otherwise stay in ACCESS.
- **RESPOND:**
  - `o_psel=0`, `o_penable=0`, `bus_if.ready=1` for exactly one cycle.
  - `bus_if.status` and `bus_if.read_data` hold the captured values.
  - Always goes to IDLE.
- **Response hold:** `status` and `read_data` keep their values until the next capture. Upstream may sample them while `ready` is high.
- **Back-to-back requests:** upstream drops `valid` on the edge that ends RESPOND, so IDLE never re-accepts a completed request. A new request accepted in IDLE starts a fresh transfer without an idle gap beyond that IDLE cycle.
- **Stability:** APB address, data, strobe and write outputs are stable from SETUP through ACCESS, per APB.
- **`valid` deasserted outside IDLE:** protocol violation by upstream. The bridge ignores it and completes the transfer.
- **Reset mid-operation:**
  - The FSM returns to IDLE immediately and all outputs take their reset values.
  - The APB transfer is abandoned and no response is produced.

## Timing
- **Reset values:** `o_psel=0`, `o_penable=0`, `o_pwrite=0`, `o_paddr=0`, `o_pwdata=0`, `o_pstrb=0`, `o_pprot=0`, `bus_if.ready=0`, `bus_if.status=2'b00`, `bus_if.read_data=0`.
- All outputs are registered. There is no combinational path from `i_pready` or `bus_if.valid` to any output.
- Minimum latency with zero-wait-state APB, counting `valid` seen in IDLE at cycle 0:
  - SETUP at cycle 1.
  - ACCESS at cycle 2 with `i_pready=1`.
  - `ready` at cycle 3.
- Each APB wait state adds one cycle.
- Throughput: at most one request per 4 cycles.

## Configuration
- **Macro:** `RGGEN_APB_BRIDGE_TIMEOUT_EN`.
- **Defined:**
  - A counter of width `$clog2(TIMEOUT_CYCLES+1)` clears on entry to ACCESS and increments each ACCESS cycle without `i_pready`.
  - When the count reaches `TIMEOUT_CYCLES` while still in ACCESS without `i_pready`, the bridge goes to RESPOND with status `2'b10` and read data 0, and drops `o_psel`/`o_penable`.
  - `i_pready` in the same cycle as the count reaching the limit wins: normal completion.
- **Undefined:** no counter; ACCESS waits indefinitely. `TIMEOUT_CYCLES` is unused.

## Test plan
- **Reset:** assert `i_rst_n=0` with `valid=1` and `pready=1` -> all outputs at reset values; after release, first transfer starts cleanly.
- **Zero-wait write:** `address=8'h10`, `write_data=32'hDEADBEEF`, `strobe=4'hF`, `pready=1` -> SETUP cycle 1, ACCESS cycle 2 with `pwrite=1`, `pstrb=4'hF`; `ready=1` at cycle 3, `status=00`, `read_data=0`.
- **Read with 3 wait states:** `address=8'h24`, `prdata=32'h12345678`, `pready` high on the 4th ACCESS cycle -> `ready` at cycle 6, `read_data=32'h12345678`, `status=00`, `pstrb=0` throughout.
- **Slave error:** read with `pslverr=1` and `pready=1` -> `status=2'b10`, single-cycle `ready`.
- **Back-to-back:** two requests via the external-register stage -> second SETUP follows IDLE directly after first RESPOND; no duplicate transfer of the first request.
- **Timeout (macro defined, `TIMEOUT_CYCLES=4`):**
  - `pready` held low -> RESPOND after 4 ACCESS cycles, `status=2'b10`.
  - Repeat with `pready` rising on the 4th ACCESS cycle -> `status=00`.
